// File: rtl/mem_access_ctrl_pkg.sv
// Op codes, FSM state encoding and decode helpers for the MEM-stage access controller.
package mem_access_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  typedef enum logic [1:0] {
    MemSt_IDLE = 2'd0,
    MemSt_WAIT = 2'd1,
    MemSt_DONE = 2'd2
  } mem_st_e;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic is_mem(input logic [7:0] op);
    return is_load(op) || is_store(op) || (op == EXE_SC_OP);
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lo);
    if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return lo[0];
    if (op inside {EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP}) return |lo;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane mapping: bus select, replicated store data and
// sign/zero-extended load extraction for the access size encoded in aluop.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [31:0] byte_shifted;
  logic [15:0] half_dat;

  // Big-endian puts byte address 0 in the top lane, so the lane index is inverted.
  assign byte_lane    = (BIG_ENDIAN != 0) ? ~addr_lo_i : addr_lo_i;
  assign half_hi      = (BIG_ENDIAN != 0) ? ~addr_lo_i[1] : addr_lo_i[1];
  assign byte_shifted = rdata_i >> {byte_lane, 3'b000};
  assign half_dat     = half_hi ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    sel_o   = 4'b1111;
    wdata_o = reg2_i;
    load_o  = rdata_i;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        sel_o   = 4'b0001 << byte_lane;
        wdata_o = {4{reg2_i[7:0]}};
        load_o  = (aluop_i == EXE_LB_OP) ? {{24{byte_shifted[7]}}, byte_shifted[7:0]}
                                         : {24'b0, byte_shifted[7:0]};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        sel_o   = half_hi ? 4'b1100 : 4'b0011;
        wdata_o = {2{reg2_i[15:0]}};
        load_o  = (aluop_i == EXE_LH_OP) ? {{16{half_dat[15]}}, half_dat}
                                         : {16'b0, half_dat};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store/LL/SC controller: runs a req/ack bus transfer while stalling
// the pipeline, else passes EX/MEM results straight through. Optional: MEM_ALIGN_EXC_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        llbit_i,
  input  logic        wb_llbit_we_i,
  input  logic        wb_llbit_value_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        llbit_we_o,
  output logic        llbit_value_o,
  output logic        stallreq_o,
`ifdef MEM_ALIGN_EXC_EN
  output logic        excp_adel_o,
  output logic        excp_ades_o,
`endif
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  mem_st_e     state_q, state_d;
  logic [31:0] addr_q, addr_d, bwdata_q, bwdata_d, rdata_q, rdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;

  logic        llbit_eff, sc_op, sc_fail, exc, bus_op, wb_nop;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, lane_load;

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .aluop_i   (aluop_i),
    .addr_lo_i (mem_addr_i[1:0]),
    .reg2_i    (reg2_i),
    .rdata_i   (rdata_q),
    .sel_o     (lane_sel),
    .wdata_o   (lane_wdata),
    .load_o    (lane_load)
  );

  // A WB-stage LLbit write is younger than the committed copy, so it wins.
  assign llbit_eff = wb_llbit_we_i ? wb_llbit_value_i : llbit_i;
  assign sc_op     = (aluop_i == EXE_SC_OP);
  assign sc_fail   = sc_op && !llbit_eff;

`ifdef MEM_ALIGN_EXC_EN
  assign exc         = is_mem(aluop_i) && misaligned(aluop_i, mem_addr_i[1:0]);
  assign excp_adel_o = exc && is_load(aluop_i);
  assign excp_ades_o = exc && !is_load(aluop_i);
`else
  assign exc = 1'b0;
`endif

  assign bus_op = is_mem(aluop_i) && !sc_fail && !exc;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    sel_d         = sel_q;
    we_d          = we_q;
    bwdata_d      = bwdata_q;
    rdata_d       = rdata_q;
    bus_req_o     = 1'b0;
    bus_we_o      = 1'b0;
    bus_addr_o    = '0;
    bus_sel_o     = '0;
    bus_wdata_o   = '0;
    stallreq_o    = 1'b0;
    wb_nop        = 1'b0;
    wd_o          = wd_i;
    wreg_o        = wreg_i;
    wdata_o       = wdata_i;
    whilo_o       = whilo_i;
    hi_o          = hi_i;
    lo_o          = lo_i;
    llbit_we_o    = 1'b0;
    llbit_value_o = 1'b0;
    case (state_q)
      MemSt_IDLE: begin
        if (bus_op) begin
          wb_nop = 1'b1;
          if (!rst) begin
            addr_d      = {mem_addr_i[31:2], 2'b00};
            sel_d       = lane_sel;
            we_d        = !is_load(aluop_i);
            bwdata_d    = lane_wdata;
            bus_req_o   = 1'b1;
            bus_we_o    = we_d;
            bus_addr_o  = addr_d;
            bus_sel_o   = sel_d;
            bus_wdata_o = bwdata_d;
            stallreq_o  = 1'b1;
            state_d     = MemSt_WAIT;
          end
        end else if (exc) begin
          wreg_o = 1'b0;
        end else if (sc_fail) begin
          wdata_o = '0;
        end
      end
      MemSt_WAIT: begin
        bus_req_o   = 1'b1;
        bus_we_o    = we_q;
        bus_addr_o  = addr_q;
        bus_sel_o   = sel_q;
        bus_wdata_o = bwdata_q;
        stallreq_o  = 1'b1;
        wb_nop      = 1'b1;
        if (bus_ack_i) begin
          rdata_d = bus_rdata_i;
          state_d = MemSt_DONE;
        end
      end
      MemSt_DONE: begin
        // EX/MEM is still frozen here, so the op and address are those that launched the access.
        state_d = MemSt_IDLE;
        if (is_load(aluop_i)) wdata_o = lane_load;
        if (aluop_i == EXE_LL_OP) begin
          llbit_we_o    = 1'b1;
          llbit_value_o = 1'b1;
        end
        if (sc_op) begin
          wdata_o    = 32'd1;
          llbit_we_o = 1'b1;
        end
      end
      default: state_d = MemSt_IDLE;
    endcase
    if (wb_nop) begin
      wd_o    = '0;
      wreg_o  = 1'b0;
      wdata_o = '0;
      whilo_o = 1'b0;
      hi_o    = '0;
      lo_o    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MemSt_IDLE;
      addr_q   <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      bwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      bwdata_q <= bwdata_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl: a driver pushes predicted
// write-back/bus behaviour per op, a negedge monitor pops and compares on pipeline advance.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int unsigned BE = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop_i = '0;
  logic [31:0] mem_addr_i = '0, reg2_i = '0, wdata_i = '0, hi_i = '0, lo_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0, whilo_i = 1'b0, llbit_i = 1'b0;
  logic        wb_llbit_we_i = 1'b0, wb_llbit_value_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, llbit_we_o, llbit_value_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
  logic        excp_adel_o, excp_ades_o;
`endif

  mem_access_ctrl #(.BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .whilo_i(whilo_i), .hi_i(hi_i),
    .lo_i(lo_i), .llbit_i(llbit_i), .wb_llbit_we_i(wb_llbit_we_i),
    .wb_llbit_value_i(wb_llbit_value_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .llbit_we_o(llbit_we_o),
    .llbit_value_o(llbit_value_o), .stallreq_o(stallreq_o),
`ifdef MEM_ALIGN_EXC_EN
    .excp_adel_o(excp_adel_o), .excp_ades_o(excp_ades_o),
`endif
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        has_bus;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    int          stalls;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic        llwe, llval;
  } exp_t;

  exp_t exp_q[$];
  exp_t em;
  int   checks = 0;
  int   failures = 0;
  int   stall_cnt = 0;
  logic saw_req = 1'b0;
  logic tb_vld = 1'b0;

  localparam logic [7:0] OPS [12] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                                      EXE_LL_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP,
                                      EXE_ADD_OP, EXE_OR_OP};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: memory semantics from byte addresses, the currently driven stimulus and the ack plan.
  function automatic exp_t model(input int delay, input logic [31:0] rdata);
    exp_t e;
    logic ld, st, sc, eff;
    int a, sh;
    logic [31:0] v;
    ld  = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP};
    st  = aluop_i inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    sc  = (aluop_i == EXE_SC_OP);
    eff = wb_llbit_we_i ? wb_llbit_value_i : llbit_i;
    a   = int'(mem_addr_i[1:0]);
    e.has_bus = ld || st || (sc && eff);
    e.stalls  = e.has_bus ? delay + 1 : 0;
    e.we      = st || sc;
    e.addr    = mem_addr_i & 32'hFFFF_FFFC;
    e.sel     = 4'hF;
    e.bwdata  = reg2_i;
    v         = rdata;
    if (aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) begin
      sh = (BE != 0) ? (3 - a) * 8 : a * 8;
      e.sel = 4'(1 << (sh / 8));
      v = (rdata >> sh) & 32'hFF;
      if (aluop_i == EXE_LB_OP && v >= 32'd128) v = v | 32'hFFFF_FF00;
      e.bwdata = (reg2_i & 32'hFF) * 32'h0101_0101;
    end else if (aluop_i inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) begin
      sh = (BE != 0) ? (2 - (a & 2)) * 8 : (a & 2) * 8;
      e.sel = 4'(3 << (sh / 8));
      v = (rdata >> sh) & 32'hFFFF;
      if (aluop_i == EXE_LH_OP && v >= 32'd32768) v = v | 32'hFFFF_0000;
      e.bwdata = (reg2_i & 32'hFFFF) * 32'h0001_0001;
    end
    e.wd    = wd_i;
    e.wreg  = wreg_i;
    e.whilo = whilo_i;
    e.hi    = hi_i;
    e.lo    = lo_i;
    e.wdata = ld ? v : (sc ? (eff ? 32'd1 : 32'd0) : wdata_i);
    e.llwe  = (aluop_i == EXE_LL_OP) || (sc && eff);
    e.llval = (aluop_i == EXE_LL_OP);
    return e;
  endfunction

  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] wdat, input logic llb, input logic wbwe,
                       input logic wbval, input int delay, input logic [31:0] rdata,
                       input logic stray);
    exp_t e;
    @(posedge clk); #1;
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wdata_i = wdat;
    llbit_i = llb; wb_llbit_we_i = wbwe; wb_llbit_value_i = wbval;
    wd_i = 5'($urandom); whilo_i = 1'($urandom); hi_i = $urandom; lo_i = $urandom;
    wreg_i = (op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP}) ? 1'b0 : 1'($urandom);
    bus_rdata_i = rdata;
    bus_ack_i = stray;
    e = model(delay, rdata);
    exp_q.push_back(e);
    tb_vld = 1'b1;
    if (e.has_bus) begin
      for (int c = 1; c <= delay; c++) begin
        @(posedge clk); #1;
        bus_ack_i = (c == delay);
      end
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && tb_vld) begin
        if (bus_req_o) begin
          saw_req = 1'b1;
          if (exp_q.size() > 0 && exp_q[0].has_bus) begin
            chk("bus_addr", bus_addr_o, exp_q[0].addr);
            chk("bus_we_sel", {27'b0, bus_we_o, bus_sel_o}, {27'b0, exp_q[0].we, exp_q[0].sel});
            chk("bus_wdata", bus_wdata_o, exp_q[0].bwdata);
          end
        end
        if (stallreq_o) begin
          stall_cnt++;
        end else begin
          if (exp_q.size() == 0) begin
            chk("unexpected_advance", 32'd1, 32'd0);
          end else begin
            em = exp_q.pop_front();
            chk("wb_wdata", wdata_o, em.wdata);
            chk("wb_ctrl", {23'b0, wd_o, wreg_o, whilo_o, llbit_we_o, llbit_value_o},
                {23'b0, em.wd, em.wreg, em.whilo, em.llwe, em.llval});
            chk("wb_hi", hi_o, em.hi);
            chk("wb_lo", lo_o, em.lo);
            chk("stall_cycles", 32'(stall_cnt), 32'(em.stalls));
            chk("bus_used", {31'b0, saw_req}, {31'b0, em.has_bus});
          end
          stall_cnt = 0;
          saw_req = 1'b0;
        end
      end
    end
  end

  initial begin : main
    logic [7:0]  op;
    logic [31:0] addr;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_bus_we_sel", {27'b0, bus_we_o, bus_sel_o}, 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    chk("rst_bus_wdata", bus_wdata_o, 32'd0);
    chk("rst_stall", {31'b0, stallreq_o}, 32'd0);
    chk("rst_wb", {wdata_o[30:0], wreg_o}, 32'd0);

    issue(EXE_LW_OP,  32'h100, $urandom, $urandom, 0, 0, 0, 3, 32'hDEAD_BEEF, 0);
    issue(EXE_LB_OP,  32'h103, $urandom, $urandom, 0, 0, 0, 1, 32'h1122_33F0, 0);
    issue(EXE_LBU_OP, 32'h103, $urandom, $urandom, 0, 0, 0, 2, 32'h1122_33F0, 0);
    issue(EXE_SH_OP,  32'h102, 32'h0000_ABCD, $urandom, 0, 0, 0, 1, $urandom, 0);
    issue(EXE_LL_OP,  32'h200, $urandom, $urandom, 0, 0, 0, 1, 32'h1234_5678, 0);
    issue(EXE_SC_OP,  32'h200, $urandom, $urandom, 0, 1, 1, 2, $urandom, 0);
    issue(EXE_SC_OP,  32'h200, $urandom, $urandom, 0, 0, 0, 1, $urandom, 0);
    issue(EXE_ADD_OP, 32'h0,   $urandom, 32'h5, 0, 0, 0, 1, $urandom, 0);
    issue(EXE_LW_OP,  32'h104, $urandom, $urandom, 0, 0, 0, 1, 32'hCAFE_F00D, 1);

    for (int i = 0; i < 150; i++) begin
      op = OPS[$urandom_range(0, 11)];
      addr = $urandom;
`ifdef MEM_ALIGN_EXC_EN
      if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) addr[0] = 1'b0;
      if (op inside {EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP}) addr[1:0] = 2'b00;
`endif
      issue(op, addr, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(1, 4), $urandom, ($urandom_range(0, 3) == 0));
    end

    // Reset while waiting for ack; the late ack must not complete anything.
    @(posedge clk); #1;
    tb_vld = 1'b0;
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h300; bus_ack_i = 1'b0;
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0; whilo_i = 1'b0; hi_i = '0; lo_i = '0;
    wb_llbit_we_i = 1'b0; llbit_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("wait_req_held", {31'b0, bus_req_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = EXE_NOP_OP; bus_ack_i = 1'b1;
    #1;
    chk("rstwait_req_dropped", {31'b0, bus_req_o}, 32'd0);
    chk("rstwait_stall", {31'b0, stallreq_o}, 32'd0);
    chk("rstwait_wb_nop", {wdata_o[26:0], wd_o} | {30'b0, wreg_o, llbit_we_o}, 32'd0);
    @(posedge clk); #1;
    bus_ack_i = 1'b0; aluop_i = EXE_LW_OP; mem_addr_i = 32'h304; bus_rdata_i = 32'h0BAD_F00D;
    #1;
    chk("post_rst_idle_launch", {31'b0, bus_req_o}, 32'd1);
    chk("post_rst_addr", bus_addr_o, 32'h304);
    @(posedge clk); #1;
    bus_ack_i = 1'b1;
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    #1;
    chk("post_rst_done_stall", {31'b0, stallreq_o}, 32'd0);
    chk("post_rst_done_wdata", wdata_o, 32'h0BAD_F00D);

`ifdef MEM_ALIGN_EXC_EN
    @(posedge clk); #1;
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h101;
    #1;
    chk("adel", {31'b0, excp_adel_o}, 32'd1);
    chk("adel_no_req", {31'b0, bus_req_o}, 32'd0);
`endif

    for (int i = 0; i < 20; i++) begin
      op = OPS[$urandom_range(0, 11)];
      addr = $urandom & 32'hFFFF_FFFC;
      issue(op, addr, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(1, 3), $urandom, 1'b0);
    end

    @(posedge clk); #1;
    tb_vld = 1'b0;
    aluop_i = EXE_NOP_OP;
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
